// File: rtl/alu_operand_loader_if.sv
// Operand/mode bundle between the board-side entry block and the ALU input register.
// The master side (the loader) samples switches/buttons and drives the committed bundle.
interface alu_operand_loader_if #(
  parameter int n = 4
);
  logic [n-1:0] sw;
  logic         btn_enter;
  logic         btn_clear;
  logic [n-1:0] in1;
  logic [n-1:0] in2;
  logic [3:0]   mode;
  logic         valid;
  logic [1:0]   state;
  logic [7:0]   op_count;

  modport master (
    input  sw, btn_enter, btn_clear,
    output in1, in2, mode, valid, state, op_count
  );

  modport slave (
    output sw, btn_enter, btn_clear,
    input  in1, in2, mode, valid, state, op_count
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Debounced two-button operand entry: stages A and B, then commits {in1, in2, mode}
// atomically with a one-cycle valid pulse.
module alu_operand_loader #(
  parameter int n          = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_operand_loader_if.master   bus
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  // Rising edge of the debounced level, seen combinationally on the edge it is taken.
  function automatic logic deb_rise(input logic synced, input logic stable_lvl,
                                    input logic [CNT_W-1:0] cnt);
    return synced & ~stable_lvl & (cnt == CNT_LAST);
  endfunction

  logic [1:0]       btn_raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       stable;
  logic [CNT_W-1:0] deb_cnt [2];
  logic             enter_press;
  logic             clear_press;

  state_t           state_q;
  state_t           state_d;
  logic             load_a;
  logic             load_b;
  logic             commit;
  logic             clear_stage;

  logic [n-1:0]     a_stage;
  logic [n-1:0]     b_stage;
  logic [n-1:0]     in1_q;
  logic [n-1:0]     in2_q;
  logic [3:0]       mode_q;
  logic [3:0]       sw_mode;
  logic             valid_q;
  logic [7:0]       op_count_q;

  assign btn_raw = {bus.btn_clear, bus.btn_enter};

  // Stage p0/p1: two-flop synchroniser, then per-button debounce counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      stable  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != stable[i]) begin
          if (deb_cnt[i] == CNT_LAST) begin
            stable[i]  <= sync_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign enter_press = deb_rise(sync_p1[0], stable[0], deb_cnt[0]);
  assign clear_press = deb_rise(sync_p1[1], stable[1], deb_cnt[1]);

  if (n >= 4) begin : g_mode_wide
    assign sw_mode = bus.sw[3:0];
  end else begin : g_mode_narrow
    assign sw_mode = {{(4-n){1'b0}}, bus.sw};
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD_A;
    else       state_q <= state_d;
  end

  // Clear dominates: a simultaneous enter press is dropped.
  always_comb begin
    state_d     = state_q;
    load_a      = 1'b0;
    load_b      = 1'b0;
    commit      = 1'b0;
    clear_stage = 1'b0;
    if (clear_press) begin
      state_d     = LOAD_A;
      clear_stage = 1'b1;
    end else if (enter_press) begin
      case (state_q)
        LOAD_A:  begin load_a = 1'b1; state_d = LOAD_B;  end
        LOAD_B:  begin load_b = 1'b1; state_d = LOAD_OP; end
        LOAD_OP: begin commit = 1'b1; state_d = SHOW;    end
        SHOW:    state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  // Stage p2: staging registers and the atomically committed bundle
  always_ff @(posedge clk) begin
    if (reset) begin
      a_stage    <= '0;
      b_stage    <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      mode_q     <= '0;
      valid_q    <= 1'b0;
      op_count_q <= '0;
    end else begin
      valid_q <= commit;
      if (clear_stage) begin
        a_stage <= '0;
        b_stage <= '0;
      end else begin
        if (load_a) a_stage <= bus.sw;
        if (load_b) b_stage <= bus.sw;
      end
      if (commit) begin
        in1_q      <= a_stage;
        in2_q      <= b_stage;
        mode_q     <= sw_mode;
        op_count_q <= op_count_q + 8'd1;
      end
    end
  end

  assign bus.in1      = in1_q;
  assign bus.in2      = in2_q;
  assign bus.mode     = mode_q;
  assign bus.valid    = valid_q;
  assign bus.state    = state_q;
  assign bus.op_count = op_count_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: table of full entries plus bounce, abort,
// simultaneous-button, wrap and mid-entry reset sequences.
module tb_alu_operand_loader;
  localparam int N   = 4;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_operand_loader_if #(.n(N)) bus();

  alu_operand_loader #(.n(N), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_cnt = 0;
  int   double_valid = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) begin
    if (bus.valid) valid_cnt <= valid_cnt + 1;
    if (bus.valid && prev_valid) double_valid <= double_valid + 1;
    prev_valid <= bus.valid;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] e_in1;
    logic [3:0] e_in2;
    logic [3:0] e_mode;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [4];

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold buttons for 'hold' cycles, then release; switches move after release
  // to show they are only sampled on the press edge.
  task automatic press(input logic ent, input logic clr, input logic [3:0] s,
                       input int hold, input int rel);
    bus.sw        = s;
    bus.btn_enter = ent;
    bus.btn_clear = clr;
    tick(hold);
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    bus.sw        = ~s;
    tick(rel);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in1"},   32'(bus.in1),      32'd0);
    check({tag, "_in2"},   32'(bus.in2),      32'd0);
    check({tag, "_mode"},  32'(bus.mode),     32'd0);
    check({tag, "_valid"}, 32'(bus.valid),    32'd0);
    check({tag, "_state"}, 32'(bus.state),    32'd0);
    check({tag, "_count"}, 32'(bus.op_count), 32'd0);
  endtask

  initial begin
    int         v0;
    logic [3:0] prev_in1;
    logic [3:0] prev_in2;

    tbl[0] = '{a: 4'h3, b: 4'h5, op: 4'h2, e_in1: 4'h3, e_in2: 4'h5, e_mode: 4'h2, e_cnt: 8'd1};
    tbl[1] = '{a: 4'h0, b: 4'h0, op: 4'h0, e_in1: 4'h0, e_in2: 4'h0, e_mode: 4'h0, e_cnt: 8'd2};
    tbl[2] = '{a: 4'hF, b: 4'h0, op: 4'h9, e_in1: 4'hF, e_in2: 4'h0, e_mode: 4'h9, e_cnt: 8'd3};
    tbl[3] = '{a: 4'hA, b: 4'hC, op: 4'hF, e_in1: 4'hA, e_in2: 4'hC, e_mode: 4'hF, e_cnt: 8'd4};

    bus.sw        = '0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    reset         = 1'b1;
    tick(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    tick(2);

    prev_in1 = 4'h0;
    prev_in2 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      press(1'b1, 1'b0, tbl[i].a, 10, 10);
      check("tbl_state_a", 32'(bus.state), 32'd1);
      check("tbl_in1_hold_a", 32'(bus.in1), 32'(prev_in1));
      press(1'b1, 1'b0, tbl[i].b, 10, 10);
      check("tbl_state_b", 32'(bus.state), 32'd2);
      check("tbl_in2_hold_b", 32'(bus.in2), 32'(prev_in2));
      check("tbl_no_valid_early", 32'(valid_cnt - v0), 32'd0);
      press(1'b1, 1'b0, tbl[i].op, 10, 10);
      check("tbl_state_show", 32'(bus.state), 32'd3);
      check("tbl_in1",   32'(bus.in1),      32'(tbl[i].e_in1));
      check("tbl_in2",   32'(bus.in2),      32'(tbl[i].e_in2));
      check("tbl_mode",  32'(bus.mode),     32'(tbl[i].e_mode));
      check("tbl_count", 32'(bus.op_count), 32'(tbl[i].e_cnt));
      check("tbl_one_valid", 32'(valid_cnt - v0), 32'd1);
      press(1'b1, 1'b0, 4'h8, 10, 10);
      check("tbl_state_back", 32'(bus.state), 32'd0);
      check("tbl_in1_show_hold", 32'(bus.in1), 32'(tbl[i].e_in1));
      prev_in1 = tbl[i].e_in1;
      prev_in2 = tbl[i].e_in2;
    end

    // Bounce: 3 high / 1 low never reaches DEB consecutive synced highs.
    bus.sw = 4'h7;
    for (int r = 0; r < 5; r++) begin
      bus.btn_enter = 1'b1;
      tick(3);
      bus.btn_enter = 1'b0;
      tick(1);
    end
    check("bounce_no_event", 32'(bus.state), 32'd0);
    bus.btn_enter = 1'b1;
    tick(5);
    check("bounce_k4", 32'(bus.state), 32'd0);
    tick(1);
    check("bounce_k5", 32'(bus.state), 32'd1);
    bus.btn_enter = 1'b0;
    tick(10);
    check("bounce_single", 32'(bus.state), 32'd1);

    // Abort after A=7, B=9.
    press(1'b1, 1'b0, 4'h9, 10, 10);
    check("abort_state_op", 32'(bus.state), 32'd2);
    v0 = valid_cnt;
    press(1'b0, 1'b1, 4'h0, 10, 10);
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("abort_in1",   32'(bus.in1),      32'hA);
    check("abort_in2",   32'(bus.in2),      32'hC);
    check("abort_mode",  32'(bus.mode),     32'hF);
    check("abort_count", 32'(bus.op_count), 32'd4);
    press(1'b1, 1'b0, 4'h6, 10, 10);
    press(1'b1, 1'b0, 4'h1, 10, 10);
    press(1'b1, 1'b0, 4'h4, 10, 10);
    check("reentry_in1",   32'(bus.in1),      32'h6);
    check("reentry_in2",   32'(bus.in2),      32'h1);
    check("reentry_mode",  32'(bus.mode),     32'h4);
    check("reentry_count", 32'(bus.op_count), 32'd5);
    press(1'b1, 1'b0, 4'h0, 10, 10);

    // Simultaneous enter+clear in LOAD_B: clear wins, nothing staged.
    press(1'b1, 1'b0, 4'h7, 10, 10);
    check("simul_pre_state", 32'(bus.state), 32'd1);
    v0 = valid_cnt;
    press(1'b1, 1'b1, 4'hC, 10, 10);
    check("simul_state", 32'(bus.state), 32'd0);
    check("simul_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("simul_in2_hold", 32'(bus.in2), 32'h1);
    press(1'b1, 1'b0, 4'h2, 10, 10);
    press(1'b1, 1'b0, 4'h3, 10, 10);
    press(1'b1, 1'b0, 4'h1, 10, 10);
    check("simul_next_in1",  32'(bus.in1),      32'h2);
    check("simul_next_in2",  32'(bus.in2),      32'h3);
    check("simul_next_mode", 32'(bus.mode),     32'h1);
    check("simul_next_cnt",  32'(bus.op_count), 32'd6);
    press(1'b1, 1'b0, 4'h0, 10, 10);

    // Wrap: 256 commits starting from op_count=6, passing 255 -> 0.
    v0 = valid_cnt;
    for (int i = 0; i < 256; i++) begin
      press(1'b1, 1'b0, 4'hA, 8, 8);
      press(1'b1, 1'b0, 4'h5, 8, 8);
      press(1'b1, 1'b0, 4'(i), 8, 8);
      check("wrap_count", 32'(bus.op_count), 32'((7 + i) % 256));
      press(1'b1, 1'b0, 4'h0, 8, 8);
    end
    check("wrap_valid_total", 32'(valid_cnt - v0), 32'd256);
    check("wrap_no_double_valid", 32'(double_valid), 32'd0);
    check("wrap_final_mode", 32'(bus.mode), 32'hF);

    // Reset mid-entry in LOAD_OP with enter held.
    press(1'b1, 1'b0, 4'h1, 8, 8);
    press(1'b1, 1'b0, 4'h2, 8, 8);
    check("rst_mid_pre_state", 32'(bus.state), 32'd2);
    bus.sw        = 4'h3;
    bus.btn_enter = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    check_outputs_zero("rst_mid");
    tick(1);
    reset = 1'b0;
    tick(5);
    check("rst_mid_k4", 32'(bus.state), 32'd0);
    tick(1);
    check("rst_mid_k5", 32'(bus.state), 32'd1);
    bus.btn_enter = 1'b0;
    tick(10);
    check("rst_mid_single", 32'(bus.state), 32'd1);
    check("rst_mid_in1", 32'(bus.in1), 32'd0);
    check("rst_mid_count", 32'(bus.op_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
